// File: rtl/seven_segment_scanner.sv
// seven_segment_scanner: time-multiplexed driver for an N-digit common-anode
// 7-segment display. One digit slot lasts CLK_DIV clocks; the first GUARD
// clocks of every slot keep all anodes off so the previous digit's segment
// pattern cannot ghost onto the next digit. Brightness is a 16-step PWM on
// the low four bits of the slot counter. The hex word and the dots are
// snapshotted once per frame so a frame never mixes two values.
module seven_segment_scanner #(
   parameter  int N_DIGITS = 8,
   parameter  int CLK_DIV  = 50000,
   parameter  int GUARD    = 64,
   localparam int IDX_W    = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1,
   localparam int CNT_W    = $clog2(CLK_DIV)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [4*N_DIGITS-1:0] number,
   input  logic [N_DIGITS-1:0]   dots,
   input  logic [N_DIGITS-1:0]   digit_en,
   input  logic                  suppress_lz,
   input  logic [3:0]            brightness,
   output logic [6:0]            seg,
   output logic                  dp,
   output logic [N_DIGITS-1:0]   anodes,
   output logic [IDX_W-1:0]      digit_idx
);

   // Active-high {a,b,c,d,e,f,g} pattern for one hex nibble.
   function automatic logic [6:0] hex_pattern(input logic [3:0] nib);
      case (nib)
         4'h0: hex_pattern = 7'h7E;
         4'h1: hex_pattern = 7'h30;
         4'h2: hex_pattern = 7'h6D;
         4'h3: hex_pattern = 7'h79;
         4'h4: hex_pattern = 7'h33;
         4'h5: hex_pattern = 7'h5B;
         4'h6: hex_pattern = 7'h5F;
         4'h7: hex_pattern = 7'h70;
         4'h8: hex_pattern = 7'h7F;
         4'h9: hex_pattern = 7'h7B;
         4'hA: hex_pattern = 7'h77;
         4'hB: hex_pattern = 7'h1F;
         4'hC: hex_pattern = 7'h4E;
         4'hD: hex_pattern = 7'h3D;
         4'hE: hex_pattern = 7'h4F;
         default: hex_pattern = 7'h47;
      endcase
   endfunction

   logic [CNT_W-1:0]      cnt;
   logic [IDX_W-1:0]      idx;
   logic                  tick;
   logic                  frame_wrap;
   logic                  first_q;
   logic [4*N_DIGITS-1:0] shadow_num;
   logic [N_DIGITS-1:0]   shadow_dots;
   logic [4*N_DIGITS-1:0] view_num;
   logic [N_DIGITS-1:0]   view_dots;
   logic [3:0]            nib;
   logic                  upper_zero;
   logic                  blank;
   logic                  active;
   logic [N_DIGITS-1:0]   anodes_nxt;

   assign tick       = (cnt == CNT_W'(CLK_DIV - 1));
   assign frame_wrap = tick && (idx == IDX_W'(N_DIGITS - 1));
   assign digit_idx  = idx;

   // Slot counter and digit index; timing never depends on data inputs.
   // NOTE: every register is written with <= so all flops sample the values
   // from before the edge, independent of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt <= '0;
         idx <= '0;
      end else begin
         cnt <= tick ? '0 : cnt + CNT_W'(1);
         if (tick)
            idx <= (idx == IDX_W'(N_DIGITS - 1)) ? '0 : idx + IDX_W'(1);
      end
   end

   // Per-frame snapshot of value and dots, also taken on the first cycle out of reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         first_q     <= 1'b1;
         shadow_num  <= '0;
         shadow_dots <= '0;
      end else begin
         first_q <= 1'b0;
         if (first_q || frame_wrap) begin
            shadow_num  <= number;
            shadow_dots <= dots;
         end
      end
   end

   // Digit under scan: nibble, leading-zero blanking and anode gating.
   // NOTE: every variable gets a default before any branch, so no latch is inferred.
   always_comb begin
      // The snapshot is not loaded until the end of the first cycle after
      // reset, so that one cycle decodes the live inputs it is capturing.
      view_num   = first_q ? number : shadow_num;
      view_dots  = first_q ? dots   : shadow_dots;
      nib        = view_num[{idx, 2'b00} +: 4];
      upper_zero = 1'b1;
      for (int j = 0; j < N_DIGITS; j++) begin
         if ((j >= int'(idx)) && (view_num[4*j +: 4] != 4'h0))
            upper_zero = 1'b0;
      end
      blank      = suppress_lz && (idx != '0) && upper_zero;
      active     = (cnt >= CNT_W'(GUARD)) && (cnt[3:0] <= brightness) && digit_en[idx];
      anodes_nxt = '1;
      if (active)
         anodes_nxt[idx] = 1'b0;
   end

   // Registered board outputs; segments stay driven all slot, only anodes and dp are gated.
   always_ff @(posedge clk) begin
      if (reset) begin
         seg    <= 7'h7F;
         dp     <= 1'b1;
         anodes <= '1;
      end else begin
         seg    <= blank ? 7'h7F : ~hex_pattern(nib);
         dp     <= active ? ~view_dots[idx] : 1'b1;
         anodes <= anodes_nxt;
      end
   end

endmodule

// File: tb/tb_seven_segment_scanner.sv
// tb_seven_segment_scanner: checks the scanner against a time-based model.
// The model derives slot and in-slot position from the number of cycles since
// reset and rebuilds the displayed digit from a per-frame copy of the inputs.
module tb_seven_segment_scanner;

   localparam int ND    = 4;
   localparam int DIV   = 32;
   localparam int GRD   = 4;
   localparam int FRAME = ND * DIV;

   logic          clk = 1'b0;
   logic          reset;
   logic [15:0]   number;
   logic [3:0]    dots;
   logic [3:0]    digit_en;
   logic          suppress_lz;
   logic [3:0]    brightness;
   logic [6:0]    seg;
   logic          dp;
   logic [3:0]    anodes;
   logic [1:0]    digit_idx;

   seven_segment_scanner #(.N_DIGITS(ND), .CLK_DIV(DIV), .GUARD(GRD)) dut (
      .clk         (clk),
      .reset       (reset),
      .number      (number),
      .dots        (dots),
      .digit_en    (digit_en),
      .suppress_lz (suppress_lz),
      .brightness  (brightness),
      .seg         (seg),
      .dp          (dp),
      .anodes      (anodes),
      .digit_idx   (digit_idx)
   );

   always #5 clk = ~clk;

   logic [6:0] dec_tbl [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

   int         n_cmp = 0;
   int         n_bad = 0;
   int         t = 0;
   int         first_low = -1;
   logic [15:0] snap_num;
   logic [3:0]  snap_dots;
   logic [6:0]  exp_seg = 7'h7F;
   logic        exp_dp  = 1'b1;
   logic [3:0]  exp_an  = 4'hF;
   logic [6:0]  seg_log [1024];
   logic        dp_log  [1024];
   logic [3:0]  an_log  [1024];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d since reset)", name, act, req, t);
      end
   endtask

   // Compare this cycle's outputs, then apply reset value r for the cycle and
   // predict the outputs the next cycle must show.
   task automatic step(input logic r);
      int         cnt;
      int         slot;
      logic [3:0] nib;
      logic       act;
      logic       blank;
      check("seg", 32'(seg), 32'(exp_seg));
      check("dp", 32'(dp), 32'(exp_dp));
      check("anodes", 32'(anodes), 32'(exp_an));
      check("digit_idx", 32'(digit_idx), 32'((t / DIV) % ND));
      if (t < 1024) begin
         seg_log[t] = seg;
         dp_log[t]  = dp;
         an_log[t]  = anodes;
      end
      if (anodes !== 4'hF && first_low < 0)
         first_low = t;
      reset = r;
      if (r) begin
         exp_seg   = 7'h7F;
         exp_dp    = 1'b1;
         exp_an    = 4'hF;
         t         = 0;
         first_low = -1;
      end else begin
         if (t == 0) begin
            snap_num  = number;
            snap_dots = dots;
         end
         cnt   = t % DIV;
         slot  = (t / DIV) % ND;
         nib   = snap_num[4*slot +: 4];
         act   = (cnt >= GRD) && ((cnt % 16) <= int'(brightness)) && digit_en[slot];
         blank = suppress_lz && (slot != 0) && ((snap_num >> (4 * slot)) == 16'h0);
         exp_seg = blank ? 7'h7F : ~dec_tbl[nib];
         exp_dp  = act ? ~snap_dots[slot] : 1'b1;
         exp_an  = act ? ~(4'b0001 << slot) : 4'hF;
         if (t % FRAME == FRAME - 1) begin
            snap_num  = number;
            snap_dots = dots;
         end
         t++;
      end
      @(negedge clk);
   endtask

   task automatic run_until(input int target);
      while (t < target)
         step(1'b0);
   endtask

   function automatic int count_low(input int lo, input int hi);
      int n = 0;
      for (int i = lo; i <= hi; i++)
         if (an_log[i] !== 4'hF)
            n++;
      return n;
   endfunction

   function automatic logic [15:0] rand_number();
      logic [15:0] v = '0;
      for (int i = 0; i < 4; i++)
         v[4*i +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      return v;
   endfunction

   initial begin
      reset       = 1'b1;
      number      = 16'h12AF;
      dots        = 4'h0;
      digit_en    = 4'hF;
      suppress_lz = 1'b0;
      brightness  = 4'd15;
      @(negedge clk);
      repeat (3) step(1'b1);

      // 12AF at full brightness, no blanking.
      run_until(250);
      number = 16'h0030;
      suppress_lz = 1'b1;
      dots = 4'b0010;
      run_until(380);
      number = 16'h0000;
      run_until(510);
      number = 16'h1111;
      suppress_lz = 1'b0;
      dots = 4'h0;
      brightness = 4'd0;
      run_until(650);
      brightness = 4'd7;
      run_until(710);
      number = 16'h2222;
      run_until(770);
      digit_en = 4'b1011;
      run_until(900);

      // Hand-derived expectations that pin the model.
      check("lit_reset_anodes", 32'(an_log[0]), 32'hF);
      check("lit_reset_seg", 32'(seg_log[0]), 32'h7F);
      check("lit_reset_dp", 32'(dp_log[0]), 32'h1);
      check("lit_first_low", first_low, 5);
      check("lit_duty15", count_low(1, 32), 28);
      check("lit_slot0_seg", 32'(seg_log[20]), 32'h38);
      check("lit_slot0_an", 32'(an_log[20]), 32'hE);
      check("lit_slot1_seg", 32'(seg_log[52]), 32'h08);
      check("lit_slot1_an", 32'(an_log[52]), 32'hD);
      check("lit_slot2_seg", 32'(seg_log[84]), 32'h12);
      check("lit_slot2_an", 32'(an_log[84]), 32'hB);
      check("lit_slot3_seg", 32'(seg_log[116]), 32'h4F);
      check("lit_slot3_an", 32'(an_log[116]), 32'h7);
      check("lit_lz_d0", 32'(seg_log[276]), 32'h01);
      check("lit_lz_d1", 32'(seg_log[308]), 32'h06);
      check("lit_lz_d1_dp", 32'(dp_log[308]), 32'h0);
      check("lit_lz_d2", 32'(seg_log[340]), 32'h7F);
      check("lit_lz_d3", 32'(seg_log[372]), 32'h7F);
      check("lit_zero_d0", 32'(seg_log[404]), 32'h01);
      check("lit_zero_d1", 32'(seg_log[436]), 32'h7F);
      // Brightness 0: only cnt 16 qualifies, cnt 0 lies inside the guard.
      check("lit_duty0", count_low(513, 544), 1);
      // Switch to 7 at cnt 10: cnt 16..23 light.
      check("lit_duty_switch", count_low(641, 672), 8);
      check("lit_tear_s2", 32'(seg_log[724]), 32'h4F);
      check("lit_tear_s3", 32'(seg_log[756]), 32'h4F);
      check("lit_next_frame", 32'(seg_log[788]), 32'h12);
      check("lit_disabled_s2", count_low(833, 864), 0);
      check("lit_after_disabled_s3", count_low(865, 896), 12);

      // Randomized inputs, changed at arbitrary points within frames.
      for (int k = 0; k < 1500; k++) begin
         if ($urandom_range(0, 15) == 0) number = rand_number();
         if ($urandom_range(0, 15) == 0) dots = 4'($urandom);
         if ($urandom_range(0, 15) == 0) digit_en = 4'($urandom);
         if ($urandom_range(0, 31) == 0) suppress_lz = 1'($urandom);
         if ($urandom_range(0, 15) == 0) brightness = 4'($urandom);
         step(1'b0);
      end

      // Reset in slot 3 at cnt 17.
      digit_en = 4'hF;
      brightness = 4'd15;
      while (t % FRAME != 3 * DIV + 17)
         step(1'b0);
      step(1'b1);
      check("lit_midreset_anodes", 32'(anodes), 32'hF);
      check("lit_midreset_idx", 32'(digit_idx), 32'h0);
      repeat (40) step(1'b0);
      check("lit_midreset_first_low", first_low, 5);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
